// File: rtl/keypad_pkg.sv
// Shared constants, key map and FSM/frame types for the 4x4 keypad scan sequencer.
package keypad_pkg;

   localparam logic [3:0] ROW0 = 4'b1110;
   localparam logic [3:0] ROW1 = 4'b1101;
   localparam logic [3:0] ROW2 = 4'b1011;
   localparam logic [3:0] ROW3 = 4'b0111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAND     = 2'd1,
      PRESSED  = 2'd2,
      REL_WAIT = 2'd3
   } key_state_t;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } frame_result_t;

   // Whole debounce FSM state lives in one struct so it can be probed as a unit.
   typedef struct packed {
      key_state_t state;
      logic [3:0] cnt;
      logic [3:0] cand;
   } fsm_t;

   function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      code = 4'h0;
      case ({row_idx, col_idx})
         4'h0: code = 4'h7;
         4'h1: code = 4'h4;
         4'h2: code = 4'h1;
         4'h3: code = 4'h0;
         4'h4: code = 4'h8;
         4'h5: code = 4'h5;
         4'h6: code = 4'h2;
         4'h7: code = 4'hA;
         4'h8: code = 4'h9;
         4'h9: code = 4'h6;
         4'hA: code = 4'h3;
         4'hB: code = 4'hB;
         4'hC: code = 4'hC;
         4'hD: code = 4'hD;
         4'hE: code = 4'hE;
         default: code = 4'hF;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Row strobe divider/rotation and per-frame column accumulation; reports one
// frame result (NONE/SINGLE/MULTI), its code and the bitmap of keys seen.
module keypad_row_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 250000
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    keypad_col,
   output logic [3:0]    keypad_row,
   output logic          frame_done,
   output frame_result_t frame_result,
   output logic [3:0]    frame_code,
   output logic [15:0]   frame_keys
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic             tick;
   logic             row_ok;
   logic [1:0]       row_idx;
   logic [3:0]       col_low;
   logic [2:0]       n_low;
   logic [1:0]       col_idx;
   logic [3:0]       row_code;
   logic [15:0]      row_keys;
   logic [2:0]       tot;

   logic [1:0]       acc_cnt;
   logic [3:0]       acc_code;
   logic [15:0]      acc_keys;

   assign tick       = (div_q == DIV_LAST);
   assign frame_done = tick && row_ok && (row_idx == 2'd3);

   always_comb begin
      row_ok  = 1'b1;
      row_idx = 2'd0;
      case (keypad_row)
         ROW0:    row_idx = 2'd0;
         ROW1:    row_idx = 2'd1;
         ROW2:    row_idx = 2'd2;
         ROW3:    row_idx = 2'd3;
         default: row_ok  = 1'b0;
      endcase

      col_low  = ~keypad_col;
      n_low    = 3'd0;
      col_idx  = 2'd0;
      row_keys = '0;
      for (int c = 0; c < 4; c++) begin
         if (col_low[c]) begin
            n_low = n_low + 3'd1;
            col_idx = 2'(c);
            row_keys[key_map(row_idx, 2'(c))] = 1'b1;
         end
      end
      row_code = key_map(row_idx, col_idx);

      // acc_cnt saturates at 2, so the sum never exceeds 6.
      tot        = {1'b0, acc_cnt} + n_low;
      frame_keys = acc_keys | row_keys;
      frame_code = (n_low == 3'd1) ? row_code : acc_code;
      if (tot == 3'd0)      frame_result = NONE;
      else if (tot == 3'd1) frame_result = SINGLE;
      else                  frame_result = MULTI;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q      <= '0;
         keypad_row <= ROW0;
         acc_cnt    <= 2'd0;
         acc_code   <= 4'h0;
         acc_keys   <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            // Frame end or a corrupted strobe both restart a clean frame on row 0.
            if (!row_ok || row_idx == 2'd3) begin
               keypad_row <= ROW0;
               acc_cnt    <= 2'd0;
               acc_code   <= 4'h0;
               acc_keys   <= '0;
            end else begin
               keypad_row <= {keypad_row[2:0], 1'b1};
               acc_cnt    <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
               acc_code   <= frame_code;
               acc_keys   <= frame_keys;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_scan_sequencer.sv
// 4x4 keypad scanner with frame-based debounce and a one-entry valid/ready event buffer.
// Optional release events: define KEYPAD_RELEASE_EVENT_EN.
module keypad_scan_sequencer
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 250000,
   parameter int DEBOUNCE_SCANS = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] keypad_col,
   output logic [3:0] keypad_row,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_release,
   input  logic       key_ready,
   output logic       key_held,
   output logic       multi_key,
   output logic       key_overflow,
   input  logic       ovf_clr
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

   logic          frame_done;
   frame_result_t frame_result;
   logic [3:0]    frame_code;
   logic [15:0]   frame_keys;

   fsm_t       fsm_q, fsm_d;
   logic [3:0] cnt_inc;
   logic       cand_seen;
   logic       ev_raise;
   logic       accept;
   logic       load;
   logic       drop;
`ifdef KEYPAD_RELEASE_EVENT_EN
   logic       ev_rel;
`endif

   keypad_row_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .clk          (clk),
      .rst          (rst),
      .keypad_col   (keypad_col),
      .keypad_row   (keypad_row),
      .frame_done   (frame_done),
      .frame_result (frame_result),
      .frame_code   (frame_code),
      .frame_keys   (frame_keys)
   );

   assign cand_seen = frame_keys[fsm_q.cand];
   assign cnt_inc   = (fsm_q.cnt < DEB) ? fsm_q.cnt + 4'd1 : fsm_q.cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fsm_q <= '{state: IDLE, cnt: 4'd0, cand: 4'h0};
      else      fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d    = fsm_q;
      ev_raise = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      ev_rel   = 1'b0;
`endif
      if (frame_done) begin
         case (fsm_q.state)
            IDLE: begin
               if (frame_result == SINGLE) begin
                  fsm_d.cand = frame_code;
                  fsm_d.cnt  = 4'd1;
                  if (DEB == 4'd1) begin
                     fsm_d.state = PRESSED;
                     ev_raise    = 1'b1;
                  end else begin
                     fsm_d.state = CAND;
                  end
               end
            end
            CAND: begin
               if (frame_result == SINGLE && frame_code == fsm_q.cand) begin
                  fsm_d.cnt = cnt_inc;
                  if (cnt_inc == DEB) begin
                     fsm_d.state = PRESSED;
                     ev_raise    = 1'b1;
                  end
               end else if (frame_result == SINGLE) begin
                  fsm_d.cand = frame_code;
                  fsm_d.cnt  = 4'd1;
               end else begin
                  fsm_d.state = IDLE;
                  fsm_d.cnt   = 4'd0;
               end
            end
            PRESSED: begin
               // Extra keys alongside the held one do not count as a release.
               if (!cand_seen) begin
                  fsm_d.cnt = 4'd1;
                  if (DEB == 4'd1) begin
                     fsm_d.state = IDLE;
`ifdef KEYPAD_RELEASE_EVENT_EN
                     ev_raise = 1'b1;
                     ev_rel   = 1'b1;
`endif
                  end else begin
                     fsm_d.state = REL_WAIT;
                  end
               end
            end
            REL_WAIT: begin
               if (cand_seen) begin
                  fsm_d.state = PRESSED;
               end else if (frame_result == NONE) begin
                  fsm_d.cnt = cnt_inc;
                  if (cnt_inc == DEB) begin
                     fsm_d.state = IDLE;
`ifdef KEYPAD_RELEASE_EVENT_EN
                     ev_raise = 1'b1;
                     ev_rel   = 1'b1;
`endif
                  end
               end
            end
            default: fsm_d = fsm_q;
         endcase
      end
   end

   always_comb begin
      key_held = (fsm_q.state == PRESSED) || (fsm_q.state == REL_WAIT);
   end

   // Handshake: an event is offered while key_valid=1 with key_code/key_release held
   // constant; it is consumed on any clock edge where key_valid && key_ready.
   assign accept = key_valid && key_ready;
   assign load   = ev_raise && (!key_valid || accept);
   assign drop   = ev_raise && key_valid && !accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid    <= 1'b0;
         key_code     <= 4'h0;
         key_overflow <= 1'b0;
         multi_key    <= 1'b0;
      end else begin
         if (load) begin
            key_valid <= 1'b1;
            key_code  <= fsm_d.cand;
         end else if (accept) begin
            key_valid <= 1'b0;
         end
         if (drop)         key_overflow <= 1'b1;
         else if (ovf_clr) key_overflow <= 1'b0;
         if (frame_done) multi_key <= (frame_result == MULTI);
      end
   end

`ifdef KEYPAD_RELEASE_EVENT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      key_release <= 1'b0;
      else if (load) key_release <= ev_rel;
   end
`else
   assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// Directed bench for keypad_scan_sequencer with SCAN_DIV=4, DEBOUNCE_SCANS=3;
// expectations adapt when KEYPAD_RELEASE_EVENT_EN is defined.
`timescale 1ns/1ps
module tb_keypad_scan_sequencer;

   localparam int FRAME = 16;
`ifdef KEYPAD_RELEASE_EVENT_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] keypad_col;
   logic [3:0] keypad_row;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_release;
   logic       key_ready = 1'b0;
   logic       key_held;
   logic       multi_key;
   logic       key_overflow;
   logic       ovf_clr = 1'b0;

   logic [15:0] keys_down = '0;
   int          kmap [4][4] = '{'{7, 4, 1, 0}, '{8, 5, 2, 10}, '{9, 6, 3, 11}, '{12, 13, 14, 15}};
   logic [4:0]  exp_q [$];
   logic [4:0]  exp_ev;
   int          checks = 0;
   int          errors = 0;
   int          cyc_cnt = 0;

   keypad_scan_sequencer #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .keypad_col   (keypad_col),
      .keypad_row   (keypad_row),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_release  (key_release),
      .key_ready    (key_ready),
      .key_held     (key_held),
      .multi_key    (multi_key),
      .key_overflow (key_overflow),
      .ovf_clr      (ovf_clr)
   );

   // clock / reset
   always #5 clk = ~clk;

   // keypad matrix: a pressed key pulls its column low while its row is strobed
   always_comb begin
      keypad_col = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!keypad_row[r])
            for (int c = 0; c < 4; c++)
               if (keys_down[kmap[r][c]]) keypad_col[c] = 1'b0;
   end

   // scoreboard: every accepted event must match the head of exp_q
   always begin
      @(negedge clk);
      #1;
      if (rst && key_valid && key_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL hs_unexpected observed=%h expected=none", {key_release, key_code});
         end else begin
            exp_ev = exp_q.pop_front();
            assert ({key_release, key_code} === exp_ev) else begin
               errors++;
               $error("FAIL hs_event observed=%h expected=%h", {key_release, key_code}, exp_ev);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc_cnt++;
      end
   endtask

   task automatic frames(input int n);
      cyc(FRAME * n);
   endtask

   task automatic align();
      if (cyc_cnt % FRAME != 0) cyc(FRAME - (cyc_cnt % FRAME));
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_row", 16'(keypad_row), 16'hE);
      chk("rst_valid", 16'(key_valid), 16'h0);
      chk("rst_code", 16'(key_code), 16'h0);
      chk("rst_held", 16'(key_held), 16'h0);
      chk("rst_multi", 16'(multi_key), 16'h0);
      chk("rst_ovf", 16'(key_overflow), 16'h0);
      rst = 1'b1;
      cyc_cnt = 0;

      // idle scan: row steps every SCAN_DIV clocks
      cyc(3); chk("scan_row0", 16'(keypad_row), 16'hE);
      cyc(1); chk("scan_row1", 16'(keypad_row), 16'hD);
      cyc(4); chk("scan_row2", 16'(keypad_row), 16'hB);
      cyc(4); chk("scan_row3", 16'(keypad_row), 16'h7);
      cyc(4); chk("scan_wrap", 16'(keypad_row), 16'hE);
      chk("scan_valid", 16'(key_valid), 16'h0);

      // key 2 held for 4 frames, consumer always ready
      key_ready = 1'b1;
      keys_down = 16'(1) << 2;
      exp_q.push_back({1'b0, 4'h2});
      cyc(3 * FRAME - 1); chk("k2_early", 16'(key_valid), 16'h0);
      cyc(1);
      chk("k2_valid", 16'(key_valid), 16'h1);
      chk("k2_code", 16'(key_code), 16'h2);
      chk("k2_rel", 16'(key_release), 16'h0);
      chk("k2_held", 16'(key_held), 16'h1);
      cyc(1); chk("k2_drop", 16'(key_valid), 16'h0);
      align();
      chk("k2_frame4_held", 16'(key_held), 16'h1);
      chk("k2_frame4_valid", 16'(key_valid), 16'h0);
      keys_down = '0;
      if (REL_EN) exp_q.push_back({1'b1, 4'h2});
      frames(2); chk("k2_relwait_held", 16'(key_held), 16'h1);
      frames(1); chk("k2_released", 16'(key_held), 16'h0);

      // key 5 bounces: present, absent, present x3
      keys_down = 16'(1) << 5; frames(1);
      keys_down = '0;          frames(1);
      keys_down = 16'(1) << 5; frames(2);
      chk("k5_no_event", 16'(key_valid), 16'h0);
      chk("k5_not_held", 16'(key_held), 16'h0);
      exp_q.push_back({1'b0, 4'h5});
      frames(1);
      chk("k5_valid", 16'(key_valid), 16'h1);
      chk("k5_code", 16'(key_code), 16'h5);
      chk("k5_multi", 16'(multi_key), 16'h0);
      keys_down = '0;
      if (REL_EN) exp_q.push_back({1'b1, 4'h5});
      frames(3); chk("k5_released", 16'(key_held), 16'h0);
      cyc(2); chk("k5_flushed", 16'(key_valid), 16'h0);
      align();

      // consumer stalled: 7 buffered, 9 dropped, overflow handling
      key_ready = 1'b0;
      keys_down = 16'(1) << 7;
      exp_q.push_back({1'b0, 4'h7});
      frames(3);
      chk("k7_valid", 16'(key_valid), 16'h1);
      chk("k7_code", 16'(key_code), 16'h7);
      keys_down = '0;
      frames(3);
      chk("k7_rel_held", 16'(key_held), 16'h0);
      chk("k7_rel_code", 16'(key_code), 16'h7);
      chk("k7_rel_flag", 16'(key_release), 16'h0);
      chk("k7_rel_ovf", 16'(key_overflow), 16'(REL_EN));
      keys_down = 16'(1) << 9;
      frames(2);
      ovf_clr = 1'b1;
      cyc(2); chk("ovf_cleared", 16'(key_overflow), 16'h0);
      cyc(14);
      chk("k9_drop_ovf", 16'(key_overflow), 16'h1);
      chk("k9_drop_valid", 16'(key_valid), 16'h1);
      chk("k9_drop_code", 16'(key_code), 16'h7);
      chk("k9_held", 16'(key_held), 16'h1);
      ovf_clr = 1'b0;
      cyc(1); chk("ovf_sticky", 16'(key_overflow), 16'h1);
      ovf_clr = 1'b1;
      cyc(1); chk("ovf_clr", 16'(key_overflow), 16'h0);
      ovf_clr = 1'b0;
      keys_down = '0;
      align();
      frames(2);
      chk("k9_released", 16'(key_held), 16'h0);
      chk("k9_rel_ovf", 16'(key_overflow), 16'(REL_EN));
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      chk("ovf_clr2", 16'(key_overflow), 16'h0);
      align();

      // new event (8) raised on the same edge that accepts the stale 7
      keys_down = 16'(1) << 8;
      exp_q.push_back({1'b0, 4'h8});
      cyc(3 * FRAME - 1);
      key_ready = 1'b1;
      cyc(1);
      chk("k8_valid", 16'(key_valid), 16'h1);
      chk("k8_code", 16'(key_code), 16'h8);
      chk("k8_no_ovf", 16'(key_overflow), 16'h0);
      cyc(1); chk("k8_accepted", 16'(key_valid), 16'h0);
      keys_down = '0;
      if (REL_EN) exp_q.push_back({1'b1, 4'h8});
      align();
      frames(2); chk("k8_released", 16'(key_held), 16'h0);
      cyc(2); align();

      // keys 1 and 3 together, then 1 alone
      keys_down = (16'(1) << 1) | (16'(1) << 3);
      frames(1);
      chk("multi_set", 16'(multi_key), 16'h1);
      chk("multi_no_event", 16'(key_valid), 16'h0);
      frames(1);
      chk("multi_still", 16'(multi_key), 16'h1);
      chk("multi_not_held", 16'(key_held), 16'h0);
      keys_down = 16'(1) << 1;
      exp_q.push_back({1'b0, 4'h1});
      frames(1);
      chk("multi_clear", 16'(multi_key), 16'h0);
      chk("k1_pending", 16'(key_valid), 16'h0);
      frames(2);
      chk("k1_valid", 16'(key_valid), 16'h1);
      chk("k1_code", 16'(key_code), 16'h1);
      keys_down = '0;
      if (REL_EN) exp_q.push_back({1'b1, 4'h1});
      frames(3); chk("k1_released", 16'(key_held), 16'h0);
      cyc(2); align();

      // key F press and release
      keys_down = 16'(1) << 15;
      exp_q.push_back({1'b0, 4'hF});
      frames(3);
      chk("kf_valid", 16'(key_valid), 16'h1);
      chk("kf_code", 16'(key_code), 16'hF);
      chk("kf_rel_flag", 16'(key_release), 16'h0);
      keys_down = '0;
      if (REL_EN) exp_q.push_back({1'b1, 4'hF});
      frames(3);
      chk("kf_released", 16'(key_held), 16'h0);
      chk("kf_rel_valid", 16'(key_valid), 16'(REL_EN));
      chk("kf_rel_code", 16'(key_code), 16'hF);
      chk("kf_rel_release", 16'(key_release), 16'(REL_EN));
      cyc(2); align();

      // asynchronous reset in the middle of CAND
      keys_down = 16'(1) << 4;
      frames(1);
      cyc(5);
      chk("cand_row_pre", 16'(keypad_row), 16'hD);
      rst = 1'b0;
      #1;
      chk("arst_row", 16'(keypad_row), 16'hE);
      chk("arst_valid", 16'(key_valid), 16'h0);
      chk("arst_code", 16'(key_code), 16'h0);
      chk("arst_rel", 16'(key_release), 16'h0);
      chk("arst_held", 16'(key_held), 16'h0);
      chk("arst_multi", 16'(multi_key), 16'h0);
      chk("arst_ovf", 16'(key_overflow), 16'h0);
      cyc(2);
      rst = 1'b1;
      cyc_cnt = 0;
      exp_q.push_back({1'b0, 4'h4});
      cyc(3 * FRAME - 1); chk("k4_restart_early", 16'(key_valid), 16'h0);
      cyc(1);
      chk("k4_valid", 16'(key_valid), 16'h1);
      chk("k4_code", 16'(key_code), 16'h4);
      cyc(2);
      keys_down = '0;
      chk("exp_q_empty", 16'(exp_q.size()), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan_sequencer.md
Name: keypad_scan_sequencer

Overview:
- Sequences the 4x4 keypad: drives one-hot-low row strobes, samples the columns per row, and debounces over whole scan frames.
- Emits debounced key-press codes on a valid/ready interface.
- Sits between the keypad pins and any consumer, such as the dot-matrix controller or a code-entry FSM.
- Replaces free-running scan-and-latch logic with a stable, handshaked event source.

Parameters:
- SCAN_DIV, 250000: clk cycles per row step; legal range 2 or more.
- DEBOUNCE_SCANS, 4: consecutive identical frames required to accept a press or a release; legal range 1 to 15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- keypad_col  input  4  column sense, active-low
- keypad_row  output  4  row strobe, one-hot-low
- key_valid  output  1  event pending
- key_code  output  4  event key code, stable while key_valid=1
- key_release  output  1  event is a release; meaningful only with the optional feature
- key_ready  input  1  consumer accepts the event
- key_held  output  1  a debounced key is currently down
- multi_key  output  1  the last frame had more than one column low
- key_overflow  output  1  sticky flag: an event was dropped
- ovf_clr  input  1  synchronous clear of key_overflow

Behaviour:
- Reset (asynchronous, rst=0): keypad_row=1110, key_valid=0, key_code=0, key_release=0, key_held=0, multi_key=0, key_overflow=0, divider=0, FSM=IDLE. Reset mid-scan or mid-debounce discards all progress.
- Divider: counts 0..SCAN_DIV-1. On the terminal count ("tick"):
  - sample keypad_col for the current row;
  - then rotate the row 1110 -> 1101 -> 1011 -> 0111 -> 1110;
  - an illegal row value recovers to 1110.
- Frame: four consecutive ticks, ending at the tick that samples row 0111. The frame result is one of:
  - NONE: no column low;
  - SINGLE(code): exactly one column low across all four rows;
  - MULTI: more than one column low.
- multi_key is updated at every frame end.
- Key map, rows indexed 0-3 for 1110/1101/1011/0111, columns indexed the same way:
  - row0 = 7, 4, 1, 0
  - row1 = 8, 5, 2, A
  - row2 = 9, 6, 3, B
  - row3 = C, D, E, F
- FSM advances only at frame end:
  - IDLE: SINGLE(c) -> CAND with cand=c, cnt=1. If DEBOUNCE_SCANS=1, go directly to PRESSED and raise a press event.
  - CAND: SINGLE(cand) -> cnt+1; on reaching DEBOUNCE_SCANS -> PRESSED and raise a press event. SINGLE(other) -> restart CAND with the new code, cnt=1. NONE or MULTI -> IDLE.
  - PRESSED: key_held=1. A frame in which cand is not low -> REL_WAIT, cnt=1. MULTI frames that still include cand remain in PRESSED.
  - REL_WAIT: key_held=1. NONE -> cnt+1; on reaching DEBOUNCE_SCANS -> IDLE and key_held=0. A frame containing cand -> PRESSED.
- Event buffer: one entry.
  - A raised event loads key_code (and key_release) and sets key_valid on the clk cycle after the frame-end tick.
  - key_valid, key_code and key_release stay stable until a cycle with key_valid && key_ready; key_valid drops on the next cycle.
  - Event raised while the buffer is full and not being accepted: the event is dropped, the buffer is untouched, key_overflow=1.
  - Event raised in the same cycle as an accepting handshake: the new event loads, no overflow.
  - ovf_clr=1 clears key_overflow. If ovf_clr coincides with a drop, the set wins.
- Latency: first press event is no sooner than DEBOUNCE_SCANS*4*SCAN_DIV cycles after the key closes, plus one cycle.
- Arithmetic: divider width is $clog2(SCAN_DIV); cnt is 4 bits and saturates at DEBOUNCE_SCANS.

Optional Feature:
- Macro: KEYPAD_RELEASE_EVENT_EN.
- Defined: the REL_WAIT -> IDLE transition also raises an event with key_code=cand and key_release=1. Press events carry key_release=0.
- Undefined: only press events are raised; key_release is constant 0.

Decomposition:
- Package keypad_pkg:
  - row constants ROW0..ROW3 (1110, 1101, 1011, 0111);
  - the key-map function (row index, column index) -> code;
  - FSM state enum {IDLE, CAND, PRESSED, REL_WAIT};
  - frame-result enum {NONE, SINGLE, MULTI}.
- Sub-module keypad_row_scanner: divider, row rotation, per-row sampling and frame-result accumulation. Outputs frame_done, frame_result and frame_code.
- Parent: debounce FSM, event buffer and overflow logic.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3.
- Reset release, no keys: keypad_row steps 1110, 1101, 1011, 0111 every 4 clk; key_valid stays 0.
- Hold row1/col2 (key 2) for 4 frames, key_ready=1: exactly one key_valid pulse with key_code=2 at frame-3 end +1 cycle; key_held=1.
- Key 5 bounces (present, absent, present, present, present frames): no event until 3 consecutive frames; exactly one event with code 5.
- key_ready=0, press 7, release, then press 9: first event holds key_code=7; 9 is dropped with key_overflow=1. Then ovf_clr -> key_overflow=0, and a handshake accepts 7.
- Keys 1 and 3 down together: multi_key=1, no event. Release 3 and keep 1 for 3 frames: event with code 1.
- With KEYPAD_RELEASE_EVENT_EN: press and release F gives events (F, release=0) then (F, release=1). Assert rst mid-CAND: all outputs return to reset values at once.
